// File: rtl/alu_control_mdu_pkg.sv
// ---------------------------------------------------------------------------
// alu_control_mdu_pkg
//   Shared definitions for the MIPS ALU control block and its multiply/divide
//   unit. It holds:
//     - the ALUCtrl operation codes, including MDU (1111), which leaves the ALU idle
//     - the R-type funct codes: the ALU set plus the eight HI/LO instructions
//     - the MDU sequencer state encoding
//     - the combinational decode helpers that the top level uses
// ---------------------------------------------------------------------------
package alu_control_mdu_pkg;

    // ALUOp value from main control meaning "R-type, look at funct"
    localparam logic [3:0] ALUOP_RTYPE = 4'b1111;

    // ALUCtrl codes
    localparam logic [3:0] CTRL_AND  = 4'b0000;
    localparam logic [3:0] CTRL_OR   = 4'b0001;
    localparam logic [3:0] CTRL_ADD  = 4'b0010;
    localparam logic [3:0] CTRL_SLL  = 4'b0011;
    localparam logic [3:0] CTRL_SRL  = 4'b0100;
    localparam logic [3:0] CTRL_SUB  = 4'b0110;
    localparam logic [3:0] CTRL_SLT  = 4'b0111;
    localparam logic [3:0] CTRL_ADDU = 4'b1000;
    localparam logic [3:0] CTRL_SUBU = 4'b1001;
    localparam logic [3:0] CTRL_XOR  = 4'b1010;
    localparam logic [3:0] CTRL_SLTU = 4'b1011;
    localparam logic [3:0] CTRL_NOR  = 4'b1100;
    localparam logic [3:0] CTRL_SRA  = 4'b1101;
    localparam logic [3:0] CTRL_LUI  = 4'b1110;
    localparam logic [3:0] CTRL_MDU  = 4'b1111;

    // R-type funct codes handled by the ALU
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    // R-type funct codes handled by the multiply/divide unit
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    // MDU sequencer states
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } mdu_state_e;

    function automatic logic is_mdu_funct(input logic [5:0] funct);
        logic hit;
        hit = 1'b0;
        case (funct)
            FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
            FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: hit = 1'b1;
            default:                            hit = 1'b0;
        endcase
        return hit;
    endfunction

    // Unknown R-type functs fall back to ADD so the datapath always has a
    // defined operation.
    function automatic logic [3:0] decode_alu_ctrl(input logic [3:0] alu_op,
                                                   input logic [5:0] funct);
        logic [3:0] ctrl;
        ctrl = CTRL_ADD;
        if (alu_op != ALUOP_RTYPE) begin
            ctrl = alu_op;
        end else begin
            case (funct)
                FN_AND:                     ctrl = CTRL_AND;
                FN_OR:                      ctrl = CTRL_OR;
                FN_ADD:                     ctrl = CTRL_ADD;
                FN_ADDU:                    ctrl = CTRL_ADDU;
                FN_SUB:                     ctrl = CTRL_SUB;
                FN_SUBU:                    ctrl = CTRL_SUBU;
                FN_XOR:                     ctrl = CTRL_XOR;
                FN_NOR:                     ctrl = CTRL_NOR;
                FN_SLT:                     ctrl = CTRL_SLT;
                FN_SLTU:                    ctrl = CTRL_SLTU;
                FN_SLL, FN_SLLV:            ctrl = CTRL_SLL;
                FN_SRL, FN_SRLV:            ctrl = CTRL_SRL;
                FN_SRA, FN_SRAV:            ctrl = CTRL_SRA;
                FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
                FN_MULT, FN_MULTU, FN_DIV, FN_DIVU:
                                            ctrl = CTRL_MDU;
                default:                    ctrl = CTRL_ADD;
            endcase
        end
        return ctrl;
    endfunction

endpackage

// File: rtl/alu_control_mdu_mdu_core.sv
// ---------------------------------------------------------------------------
// mdu_core
//   Iterative multiply/divide unit that owns the HI and LO registers.
//   - Multiply uses a radix-2 shift-add step on the operand magnitudes.
//   - Divide uses a radix-2 restoring step on the operand magnitudes.
//   - Signs are corrected in a final cycle.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting; MTHI/MTLO write HI/LO, MULT/DIV ops latch operands
//   RUN   | one radix-2 step per cycle, DATA_W steps in total
//   FIX   | two's-complement sign correction, HI/LO written
//
// Ports
//   CLK, Reset     clock, synchronous active-high reset
//   issue_i        an MDU instruction is accepted this cycle
//   funct_i        funct field of the accepted instruction
//   a_i, b_i       rs / rt operands
//   busy_o         sequencer not in IDLE
//   hi_o, lo_o     architectural HI / LO
// ---------------------------------------------------------------------------
module mdu_core
    import alu_control_mdu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              issue_i,
    input  logic [5:0]        funct_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              busy_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    mdu_state_e        state_q;
    logic [CNT_W-1:0]  count_q;
    // acc_q: upper product half (multiply) or partial remainder (divide)
    // wrk_q: multiplier shifting out (multiply) or dividend -> quotient (divide)
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] wrk_q;
    logic [DATA_W-1:0] opb_q;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic              is_div_q;
    logic              neg_lo_q;
    logic              neg_hi_q;
    logic              div0_q;

    // Operand preparation at issue
    logic              is_signed;
    logic              a_neg;
    logic              b_neg;
    logic [DATA_W-1:0] a_mag;
    logic [DATA_W-1:0] b_mag;

    assign is_signed = (funct_i == FN_MULT) || (funct_i == FN_DIV);
    assign a_neg     = is_signed & a_i[DATA_W-1];
    assign b_neg     = is_signed & b_i[DATA_W-1];
    // The most negative value maps onto itself, which is the correct
    // unsigned magnitude 2^(DATA_W-1).
    assign a_mag     = a_neg ? -a_i : a_i;
    assign b_mag     = b_neg ? -b_i : b_i;

    // One radix-2 iteration
    logic [DATA_W:0]   mul_sum;
    logic [DATA_W:0]   div_shift;
    logic              div_ge;
    logic [DATA_W-1:0] div_diff;
    logic [DATA_W-1:0] acc_d;
    logic [DATA_W-1:0] wrk_d;

    always_comb begin
        mul_sum   = {1'b0, acc_q} + {1'b0, opb_q};
        div_shift = {acc_q, wrk_q[DATA_W-1]};
        div_ge    = (div_shift >= {1'b0, opb_q});
        // Only used when div_ge holds, where the true difference fits in
        // DATA_W bits, so modulo arithmetic on the low bits is exact.
        div_diff  = div_shift[DATA_W-1:0] - opb_q;
        acc_d     = acc_q;
        wrk_d     = wrk_q;
        if (is_div_q) begin
            if (div_ge) begin
                acc_d = div_diff;
                wrk_d = {wrk_q[DATA_W-2:0], 1'b1};
            end else begin
                acc_d = div_shift[DATA_W-1:0];
                wrk_d = {wrk_q[DATA_W-2:0], 1'b0};
            end
        end else if (wrk_q[0]) begin
            acc_d = mul_sum[DATA_W:1];
            wrk_d = {mul_sum[0], wrk_q[DATA_W-1:1]};
        end else begin
            acc_d = {1'b0, acc_q[DATA_W-1:1]};
            wrk_d = {acc_q[0], wrk_q[DATA_W-1:1]};
        end
    end

    // Final sign correction
    logic [2*DATA_W-1:0] prod_mag;
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   quo_fix;
    logic [DATA_W-1:0]   rem_fix;
    logic [DATA_W-1:0]   hi_d;
    logic [DATA_W-1:0]   lo_d;

    always_comb begin
        prod_mag = {acc_q, wrk_q};
        prod_fix = neg_lo_q ? -prod_mag : prod_mag;
        quo_fix  = neg_lo_q ? -wrk_q : wrk_q;
        // The remainder takes the dividend's sign. For a zero divisor the
        // restoring loop leaves |dividend| here, so HI ends up as the
        // dividend itself.
        rem_fix  = neg_hi_q ? -acc_q : acc_q;
        if (!is_div_q) begin
            hi_d = prod_fix[2*DATA_W-1:DATA_W];
            lo_d = prod_fix[DATA_W-1:0];
        end else if (div0_q) begin
            hi_d = rem_fix;
            lo_d = '1;
        end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            wrk_q    <= '0;
            opb_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (issue_i) begin
                        case (funct_i)
                            FN_MTHI: hi_q <= a_i;
                            FN_MTLO: lo_q <= a_i;
                            FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                                is_div_q <= (funct_i == FN_DIV) || (funct_i == FN_DIVU);
                                neg_lo_q <= a_neg ^ b_neg;
                                neg_hi_q <= a_neg;
                                div0_q   <= (b_i == '0);
                                acc_q    <= '0;
                                wrk_q    <= a_mag;
                                opb_q    <= b_mag;
                                count_q  <= CNT_W'(DATA_W);
                                state_q  <= S_RUN;
                            end
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    acc_q   <= acc_d;
                    wrk_q   <= wrk_d;
                    count_q <= count_q - CNT_W'(1);
                    if (count_q == CNT_W'(1)) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o = (state_q != S_IDLE);
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: rtl/alu_control_mdu.sv
// ---------------------------------------------------------------------------
// alu_control_mdu
//   ALU control for the single-cycle MIPS core, with a multi-cycle
//   multiply/divide unit. ALUOp/FuncCode decode stays combinational.
//   Stall holds PC/IR when an MDU instruction arrives while the unit is
//   busy. Non-MDU instructions keep flowing and overlap with the unit.
//
// Ports
//   CLK, Reset   clock, synchronous active-high reset
//   InstrValid   current instruction is real (not a bubble)
//   ALUOp        main-control op; 1111 selects the funct decode
//   FuncCode     instruction funct field
//   A, B         rs / rt values
//   ALUCtrl      ALU operation code (1111 = ALU idle, MDU op)
//   MduOut       HI or LO for MFHI / MFLO, zero otherwise
//   MduSel       datapath writes MduOut instead of the ALU result
//   Stall        hold PC/IR this cycle
//   Busy         MDU iterating
// ---------------------------------------------------------------------------
module alu_control_mdu
    import alu_control_mdu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              InstrValid,
    input  logic [3:0]        ALUOp,
    input  logic [5:0]        FuncCode,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic [3:0]        ALUCtrl,
    output logic [DATA_W-1:0] MduOut,
    output logic              MduSel,
    output logic              Stall,
    output logic              Busy
);

    logic              mdu_instr;
    logic              mdu_busy;
    logic              mdu_issue;
    logic              rd_hilo;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    assign ALUCtrl = decode_alu_ctrl(ALUOp, FuncCode);

    // Nothing issues or reads while reset is applied, so the outputs stay
    // quiet during the reset cycle as well as after it.
    assign mdu_instr = InstrValid && !Reset && (ALUOp == ALUOP_RTYPE)
                       && is_mdu_funct(FuncCode);
    assign Stall     = mdu_instr && mdu_busy;
    assign mdu_issue = mdu_instr && !mdu_busy;
    assign rd_hilo   = (FuncCode == FN_MFHI) || (FuncCode == FN_MFLO);
    assign MduSel    = mdu_issue && rd_hilo;
    assign MduOut    = !MduSel ? '0 : ((FuncCode == FN_MFHI) ? hi : lo);
    assign Busy      = mdu_busy;

    mdu_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .CLK     (CLK),
        .Reset   (Reset),
        .issue_i (mdu_issue),
        .funct_i (FuncCode),
        .a_i     (A),
        .b_i     (B),
        .busy_o  (mdu_busy),
        .hi_o    (hi),
        .lo_o    (lo)
    );

endmodule
